// File: rtl/coax_rx.sv
// rtl/coax_rx.sv - 3270 coax biphase receiver; optional parity check via COAX_RX_PARITY_CHECK_EN
module coax_rx #(
    parameter int CLOCKS_PER_BIT   = 8,
    parameter int MIN_QUIESCE_BITS = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic       active,
    output logic [9:0] data,
    output logic       strobe,
    output logic       parity_error,
    output logic       error
);

    localparam logic [4:0] C_LO      = 5'(3 * CLOCKS_PER_BIT / 4);
    localparam logic [4:0] C_HI      = 5'(5 * CLOCKS_PER_BIT / 4);
    localparam logic [4:0] C_CV_MIN  = 5'(3 * CLOCKS_PER_BIT / 2 - 2);
    localparam logic [4:0] C_CV_MAX  = 5'(3 * CLOCKS_PER_BIT / 2 + 2);
    localparam logic [4:0] C_CV_LATE = 5'(3 * CLOCKS_PER_BIT / 2 + 3);
    localparam logic [3:0] C_QMIN    = 4'(MIN_QUIESCE_BITS);

    typedef enum logic [2:0] {
        S_IDLE, S_CV_HIGH, S_CV_LOW, S_SYNC, S_DATA, S_PARITY, S_END
    } state_t;

    state_t     r_state, w_nxt_state;
    logic       r_sync1, r_sync2, r_sync_d;
    logic [4:0] r_cnt;
    logic [3:0] r_qcnt, w_nxt_qcnt;
    logic [9:0] r_shift, w_nxt_shift;
    logic [3:0] r_bitidx, w_nxt_bitidx;
    logic       r_seen, w_nxt_seen;
    logic       r_active, w_nxt_active;
    logic [9:0] r_data, w_nxt_data;
    logic       r_strobe, w_nxt_strobe;
    logic       r_perr, w_nxt_perr;
    logic       r_error, w_nxt_error;
    logic       w_restart;

    logic w_edge, w_bit, w_mid, w_missing, w_cv_ok, w_cv_late;

    // Edge classification relative to the last mid-bit edge; a falling edge decodes as '1'
    assign w_edge    = r_sync2 ^ r_sync_d;
    assign w_bit     = ~r_sync2;
    assign w_mid     = w_edge && (r_cnt >= C_LO) && (r_cnt <= C_HI);
    assign w_missing = !w_edge && (r_cnt == C_HI);
    assign w_cv_ok   = (r_cnt >= C_CV_MIN) && (r_cnt <= C_CV_MAX);
    assign w_cv_late = !w_edge && (r_cnt == C_CV_LATE);

    assign active       = r_active;
    assign data         = r_data;
    assign strobe       = r_strobe;
    assign parity_error = r_perr;
    assign error        = r_error;

    // Two-flop synchroniser plus one delayed copy for edge detection; idle line is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= rx;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // Bit-cell timer: restarts on each accepted timing edge, saturates when the line is quiet
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 5'd0;
        end else if (w_restart) begin
            r_cnt <= 5'd1;
        end else if (r_cnt != 5'd31) begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_qcnt   <= 4'd0;
            r_shift  <= 10'd0;
            r_bitidx <= 4'd0;
            r_seen   <= 1'b0;
            r_active <= 1'b0;
            r_data   <= 10'd0;
            r_strobe <= 1'b0;
            r_perr   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_qcnt   <= w_nxt_qcnt;
            r_shift  <= w_nxt_shift;
            r_bitidx <= w_nxt_bitidx;
            r_seen   <= w_nxt_seen;
            r_active <= w_nxt_active;
            r_data   <= w_nxt_data;
            r_strobe <= w_nxt_strobe;
            r_perr   <= w_nxt_perr;
            r_error  <= w_nxt_error;
        end
    end

    // Next-state and output decode; strobe only comes from PARITY, so it never meets error
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_qcnt   = r_qcnt;
        w_nxt_shift  = r_shift;
        w_nxt_bitidx = r_bitidx;
        w_nxt_seen   = r_seen;
        w_nxt_active = r_active;
        w_nxt_data   = r_data;
        w_nxt_strobe = 1'b0;
        w_nxt_perr   = r_perr;
        w_nxt_error  = 1'b0;
        w_restart    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Any edge past the boundary zone resynchronises the timer while idle
                if (w_edge && (r_cnt >= C_LO)) begin
                    w_restart = 1'b1;
                    if (!w_bit)
                        w_nxt_qcnt = 4'd0;
                    else if (r_qcnt < C_QMIN)
                        w_nxt_qcnt = r_qcnt + 4'd1;
                end else if (w_missing) begin
                    if ((r_qcnt >= C_QMIN) && r_sync2)
                        w_nxt_state = S_CV_HIGH;
                    w_nxt_qcnt = 4'd0;
                end
            end
            S_CV_HIGH: begin
                if (w_edge) begin
                    if (w_cv_ok && !r_sync2) begin
                        w_nxt_state = S_CV_LOW;
                        w_restart   = 1'b1;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_error = 1'b1;
                    end
                end else if (w_cv_late) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_error = 1'b1;
                end
            end
            S_CV_LOW: begin
                if (w_edge) begin
                    if (w_cv_ok && r_sync2) begin
                        w_nxt_state  = S_SYNC;
                        w_nxt_active = 1'b1;
                        w_nxt_seen   = 1'b0;
                        w_restart    = 1'b1;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_error = 1'b1;
                    end
                end else if (w_cv_late) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_error = 1'b1;
                end
            end
            S_SYNC: begin
                if (w_mid) begin
                    w_restart = 1'b1;
                    if (w_bit) begin
                        w_nxt_state  = S_DATA;
                        w_nxt_bitidx = 4'd9;
                    end else if (r_seen) begin
                        w_nxt_state = S_END;
                    end else begin
                        w_nxt_state  = S_IDLE;
                        w_nxt_active = 1'b0;
                        w_nxt_error  = 1'b1;
                    end
                end else if (w_missing) begin
                    w_nxt_state  = S_IDLE;
                    w_nxt_active = 1'b0;
                    w_nxt_error  = 1'b1;
                end
            end
            S_DATA: begin
                if (w_mid) begin
                    w_restart   = 1'b1;
                    w_nxt_shift = {r_shift[8:0], w_bit};
                    if (r_bitidx == 4'd0)
                        w_nxt_state = S_PARITY;
                    else
                        w_nxt_bitidx = r_bitidx - 4'd1;
                end else if (w_missing) begin
                    w_nxt_state  = S_IDLE;
                    w_nxt_active = 1'b0;
                    w_nxt_error  = 1'b1;
                end
            end
            S_PARITY: begin
                if (w_mid) begin
                    w_restart    = 1'b1;
                    w_nxt_data   = r_shift;
                    w_nxt_strobe = 1'b1;
                    w_nxt_seen   = 1'b1;
                    w_nxt_state  = S_SYNC;
`ifdef COAX_RX_PARITY_CHECK_EN
                    w_nxt_perr   = w_bit ^ (^r_shift);
`else
                    w_nxt_perr   = 1'b0;
`endif
                end else if (w_missing) begin
                    w_nxt_state  = S_IDLE;
                    w_nxt_active = 1'b0;
                    w_nxt_error  = 1'b1;
                end
            end
            S_END: begin
                if (w_mid) begin
                    w_restart    = 1'b1;
                    w_nxt_state  = S_IDLE;
                    w_nxt_active = 1'b0;
                    w_nxt_error  = 1'b1;
                end else if (w_missing) begin
                    w_nxt_state  = S_IDLE;
                    w_nxt_active = 1'b0;
                end
            end
            default: begin
                w_nxt_state  = S_IDLE;
                w_nxt_active = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_coax_rx.sv
// tb/tb_coax_rx.sv - directed self-checking bench for coax_rx
module tb_coax_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       active;
    logic [9:0] data;
    logic       strobe;
    logic       parity_error;
    logic       error;

    coax_rx dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .active       (active),
        .data         (data),
        .strobe       (strobe),
        .parity_error (parity_error),
        .error        (error)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_strobe = 0;
    int n_err = 0;
    int n_both = 0;
    int n_rise = 0;
    int n_fall = 0;
    logic prev_active = 1'b0;
    logic [9:0] cap_data[$];
    logic       cap_pe[$];

    // Event monitor sampled on the falling edge
    always @(negedge clk) begin
        if (strobe === 1'b1) begin
            cap_data.push_back(data);
            cap_pe.push_back(parity_error);
            n_strobe++;
        end
        if (error === 1'b1) n_err++;
        if (strobe === 1'b1 && error === 1'b1) n_both++;
        if (active === 1'b1 && prev_active === 1'b0) n_rise++;
        if (active === 1'b0 && prev_active === 1'b1) n_fall++;
        prev_active = active;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] got_data(input int i);
        if (i < cap_data.size()) return cap_data[i];
        return 10'bx;
    endfunction

    function automatic logic got_pe(input int i);
        if (i < cap_pe.size()) return cap_pe[i];
        return 1'bx;
    endfunction

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            hold(1'b1, 4);
            hold(1'b0, 4);
        end else begin
            hold(1'b0, 4);
            hold(1'b1, 4);
        end
    endtask

    task automatic send_quiesce(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    // High 1 bit from the last mid-bit, low 1.5 bits, then high half bit before sync
    task automatic send_cv();
        hold(1'b1, 8);
        hold(1'b0, 12);
        hold(1'b1, 4);
    endtask

    task automatic send_word(input logic [9:0] w, input logic p);
        send_bit(1'b1);
        for (int i = 9; i >= 0; i--) send_bit(w[i]);
        send_bit(p);
    endtask

    int s0, e0, r0, f0, k;
    logic exp_bad_pe;

    initial begin
`ifdef COAX_RX_PARITY_CHECK_EN
        exp_bad_pe = 1'b1;
`else
        exp_bad_pe = 1'b0;
`endif
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_active", 32'(active), 32'd0);
        check("rst_strobe", 32'(strobe), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_perr", 32'(parity_error), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        reset_n = 1'b1;
        hold(1'b1, 40);

        // Single word 0x2A5
        send_quiesce(5);
        send_cv();
        check("f1_active_after_cv", 32'(active), 32'd1);
        send_word(10'h2A5, 1'b1);
        check("f1_strobe_latency", 32'(n_strobe), 32'd1);
        check("f1_data", 32'(got_data(0)), 32'h2A5);
        check("f1_perr", 32'(got_pe(0)), 32'd0);
        send_bit(1'b0);
        check("f1_active_after_end_sync", 32'(active), 32'd1);
        hold(1'b1, 16);
        check("f1_active_fall", 32'(active), 32'd0);
        check("f1_no_error", 32'(n_err), 32'd0);
        check("f1_one_strobe", 32'(n_strobe), 32'd1);

        // Three words back to back
        r0 = n_rise; f0 = n_fall;
        send_quiesce(5);
        send_cv();
        send_word(10'h000, 1'b0);
        send_word(10'h3FF, 1'b0);
        send_word(10'h155, 1'b1);
        check("f3_active_mid", 32'(active), 32'd1);
        send_bit(1'b0);
        hold(1'b1, 24);
        check("f3_strobes", 32'(n_strobe), 32'd4);
        check("f3_w0", 32'(got_data(1)), 32'h000);
        check("f3_w1", 32'(got_data(2)), 32'h3FF);
        check("f3_w2", 32'(got_data(3)), 32'h155);
        check("f3_pe", 32'({got_pe(1), got_pe(2), got_pe(3)}), 32'd0);
        check("f3_one_rise", 32'(n_rise - r0), 32'd1);
        check("f3_one_fall", 32'(n_fall - f0), 32'd1);
        check("f3_no_error", 32'(n_err), 32'd0);

        // Bad parity
        send_quiesce(5);
        send_cv();
        send_word(10'h001, 1'b0);
        send_bit(1'b0);
        hold(1'b1, 24);
        check("bp_strobes", 32'(n_strobe), 32'd5);
        check("bp_data", 32'(got_data(4)), 32'h001);
        check("bp_perr", 32'(got_pe(4)), 32'(exp_bad_pe));

        // Only four quiesce bits: no start
        s0 = n_strobe; e0 = n_err; r0 = n_rise;
        send_quiesce(4);
        send_cv();
        hold(1'b1, 40);
        check("q4_active", 32'(active), 32'd0);
        check("q4_no_rise", 32'(n_rise - r0), 32'd0);
        check("q4_no_error", 32'(n_err - e0), 32'd0);
        check("q4_no_strobe", 32'(n_strobe - s0), 32'd0);

        // Missing mid-bit edge at data bit 7
        s0 = n_strobe; e0 = n_err;
        send_quiesce(5);
        send_cv();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        hold(rx, 8);
        for (k = 0; k < 8 && n_err == e0; k++) begin
            @(posedge clk);
            #1;
        end
        check("mt_error_pulse", 32'(n_err - e0), 32'd1);
        check("mt_active", 32'(active), 32'd0);
        hold(1'b1, 40);
        check("mt_no_strobe", 32'(n_strobe - s0), 32'd0);
        send_quiesce(5);
        send_cv();
        send_word(10'h2A5, 1'b1);
        send_bit(1'b0);
        hold(1'b1, 24);
        check("mt_recover_strobe", 32'(n_strobe - s0), 32'd1);
        check("mt_recover_data", 32'(got_data(s0)), 32'h2A5);

        // Reset during data bit 4
        s0 = n_strobe; e0 = n_err;
        send_quiesce(5);
        send_cv();
        send_bit(1'b1);
        for (int i = 9; i >= 5; i--) send_bit(10'h2A5 >> i);
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        rx = 1'b1;
        #1;
        check("rm_active", 32'(active), 32'd0);
        check("rm_strobe", 32'(strobe), 32'd0);
        check("rm_error", 32'(error), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        hold(1'b1, 40);
        check("rm_no_strobe", 32'(n_strobe - s0), 32'd0);
        check("rm_no_error", 32'(n_err - e0), 32'd0);
        send_quiesce(5);
        send_cv();
        send_word(10'h2A5, 1'b1);
        send_bit(1'b0);
        hold(1'b1, 24);
        check("rm_recover_strobe", 32'(n_strobe - s0), 32'd1);
        check("rm_recover_data", 32'(got_data(s0)), 32'h2A5);
        check("rm_recover_perr", 32'(got_pe(s0)), 32'd0);
        check("rm_active_end", 32'(active), 32'd0);

        check("never_strobe_and_error", 32'(n_both), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
